// File: rtl/hash_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg
//   Shared definitions for the hash message sender: framing byte values,
//   default digest width, the sender FSM state type and a small helper that
//   recognises the framing byte values.
// ---------------------------------------------------------------------------
package hash_pkg;

   localparam logic [7:0] SOF_BYTE      = 8'hFF;
   localparam logic [7:0] EOF_BYTE      = 8'h00;
   localparam int         DIGEST_W_DEF  = 64;

   typedef enum logic [2:0] {
      IDLE,
      SOF,
      DATA,
      EOF,
      WAIT,
      DIGEST
   } sender_state_t;

   // True for byte values that collide with the frame delimiters.
   function automatic logic is_frame_byte(input logic [7:0] b);
      return (b == SOF_BYTE) || (b == EOF_BYTE);
   endfunction

endpackage

// File: rtl/hash_msg_sender_if.sv
// ---------------------------------------------------------------------------
// hash_msg_sender_if
//   Byte interface between the message sender and the hash core.
//   Signals:
//     m          byte to hash (held between strobes)
//     m_valid    1-cycle strobe, m valid that cycle
//     hash_busy  core still absorbing the previous byte
//     hash_ready digest valid
//     hash_out   digest value
//   Modports: master = sender side, slave = hash core side.
// ---------------------------------------------------------------------------
interface hash_msg_sender_if
   import hash_pkg::*;
#(
   parameter int DIGEST_W = DIGEST_W_DEF
) ();

   logic [7:0]          m;
   logic                m_valid;
   logic                hash_busy;
   logic                hash_ready;
   logic [DIGEST_W-1:0] hash_out;

   modport master (
      output m,
      output m_valid,
      input  hash_busy,
      input  hash_ready,
      input  hash_out
   );

   modport slave (
      input  m,
      input  m_valid,
      output hash_busy,
      output hash_ready,
      output hash_out
   );

endinterface

// File: rtl/hash_msg_fifo.sv
// ---------------------------------------------------------------------------
// hash_msg_fifo
//   Synchronous byte FIFO holding one host message.
//   Ports:
//     clk, reset_l  clock / asynchronous active-low clear of the pointers
//     push, din     enqueue din when not full
//     pop, dout     dout shows the head; pop advances it when not empty
//     full, empty   status
//   Pointers carry one extra wrap bit so full and empty can be told apart.
// ---------------------------------------------------------------------------
module hash_msg_fifo #(
   parameter int DEPTH = 64
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [7:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
         if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; the pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/hash_msg_sender.sv
// ---------------------------------------------------------------------------
// hash_msg_sender
//   Transmit side of the hash byte interface. Buffers one host message in a
//   byte FIFO, then on send frames it as FF, payload, 00 with one m_valid
//   strobe per byte, paced by hash_busy, and captures the digest when
//   hash_ready asserts.
//   Ports:
//     clk, reset_l        clock / asynchronous active-low reset
//     wr_data, wr_valid   host payload byte in
//     wr_ready            byte accepted (IDLE and FIFO not full)
//     send                start framing (sampled in IDLE only)
//     busy                high from accepted send until done
//     done                1-cycle pulse when the digest is captured
//     err_drop            1-cycle pulse when a payload byte is filtered
//     hash                byte interface to the hash core (master modport)
//     digest              last captured digest
//     digest_valid        set on capture, cleared on accepted send
//   Build option HASH_SEND_FILTER_EN: payload bytes 00/FF are dropped on
//   write with an err_drop pulse. Without it every byte is queued verbatim
//   and err_drop stays 0.
// ---------------------------------------------------------------------------
module hash_msg_sender
   import hash_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int GAP_CYC  = 1,
   parameter int DIGEST_W = DIGEST_W_DEF
) (
   input  logic                clk,
   input  logic                reset_l,
   input  logic [7:0]          wr_data,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic                send,
   output logic                busy,
   output logic                done,
   output logic                err_drop,
   hash_msg_sender_if.master   hash,
   output logic [DIGEST_W-1:0] digest,
   output logic                digest_valid
);

   localparam int          GW       = $clog2(GAP_CYC) + 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   sender_state_t state;
   sender_state_t nxt;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    m_r;
   logic          m_valid_r;
   logic          busy_r;
   logic          done_r;
   logic          err_r;

   logic       fifo_push;
   logic       fifo_pop;
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;
   logic       accept_wr;
   logic       drop;
   logic       gap_done;
   logic       advance;

   assign wr_ready  = (state == IDLE) && !fifo_full;
   assign accept_wr = wr_valid && wr_ready;

`ifdef HASH_SEND_FILTER_EN
   assign drop = accept_wr && is_frame_byte(wr_data);
`else
   assign drop = 1'b0;
`endif

   assign fifo_push = accept_wr && !drop;

   // The idle gap has elapsed on the last counted cycle; hash_busy is
   // sampled on that same cycle so the strobe period is GAP_CYC+1.
   assign gap_done = (gap_cnt == GAP_LAST);
   assign advance  = (state == WAIT) && gap_done && !hash.hash_busy;
   assign fifo_pop = advance && (nxt == DATA);

   hash_msg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_l (reset_l),
      .push    (fifo_push),
      .din     (wr_data),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The strobe is registered on entry to SOF/DATA/EOF, so m_valid is high
   // exactly during the cycle the FSM sits in one of those states.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state        <= IDLE;
         nxt          <= IDLE;
         gap_cnt      <= '0;
         m_r          <= '0;
         m_valid_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
      end else begin
         m_valid_r <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= drop;
         case (state)
            IDLE: begin
               if (send) begin
                  state        <= SOF;
                  m_r          <= SOF_BYTE;
                  m_valid_r    <= 1'b1;
                  busy_r       <= 1'b1;
                  digest_valid <= 1'b0;
               end
            end
            SOF, DATA: begin
               // FIFO status already reflects the pop made on DATA entry.
               gap_cnt <= '0;
               state   <= WAIT;
               nxt     <= fifo_empty ? EOF : DATA;
            end
            EOF: begin
               gap_cnt <= '0;
               state   <= WAIT;
               nxt     <= DIGEST;
            end
            WAIT: begin
               if (!gap_done) begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end else if (!hash.hash_busy) begin
                  state <= nxt;
                  case (nxt)
                     DATA: begin
                        m_r       <= fifo_dout;
                        m_valid_r <= 1'b1;
                     end
                     EOF: begin
                        m_r       <= EOF_BYTE;
                        m_valid_r <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            DIGEST: begin
               if (hash.hash_ready) begin
                  digest       <= hash.hash_out;
                  digest_valid <= 1'b1;
                  done_r       <= 1'b1;
                  busy_r       <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hash.m       = m_r;
   assign hash.m_valid = m_valid_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err_drop     = err_r;

endmodule
